// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared constants for the register-file write-port arbiter
package regfile_arb_pkg;
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter, priority goes to whoever did not win last
module rr_arbiter2
    import regfile_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic last_grant;
    // one-hot grant: a lone requester wins, contention goes to the one not granted last
    always_comb begin
        gnt = '0;
        gnt[REQ_A] = en & req[REQ_A] & (~req[REQ_B] | (last_grant == REQ_B));
        gnt[REQ_B] = en & req[REQ_B] & (~req[REQ_A] | (last_grant == REQ_A));
    end
    // remember the last winner; reset to B so A has first priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= REQ_B;
        else if (|gnt)
            last_grant <= gnt[REQ_B];
    end
endmodule

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the register-file write port between ALU (A) and load (B) writeback
module regfile_wport_arbiter #(
    parameter int DATA_W = regfile_arb_pkg::DATA_W,
    parameter int ADDR_W = regfile_arb_pkg::ADDR_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              sel,
    output logic [CNT_W-1:0]  coll_cnt
);
    import regfile_arb_pkg::*;
    logic [1:0]        gnt;
    logic              g_sel;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    logic              coll;
    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({b_valid, a_valid}),
        .en    (~hold & rst_n),
        .gnt   (gnt)
    );
    assign a_ready = gnt[REQ_A];
    assign b_ready = gnt[REQ_B];
    assign g_sel   = gnt[REQ_B];
    assign g_addr  = g_sel ? b_addr : a_addr;
    assign g_data  = g_sel ? b_data : a_data;
    assign coll    = a_valid & b_valid & ~hold;
    // register the winning write; $zero is consumed but never enabled, no-grant cycles hold the payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            sel     <= 1'b0;
        end else begin
            wr_en <= |gnt && g_addr != ADDR_W'(ZERO_REG);
            if (|gnt) begin
                wr_addr <= g_addr;
                wr_data <= g_data;
                sel     <= g_sel;
            end
        end
    end
    // saturating count of unheld cycles where both requesters compete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            coll_cnt <= '0;
        else if (coll && !(&coll_cnt))
            coll_cnt <= coll_cnt + 1'b1;
    end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: randomized self-checking bench with a behavioural write-port model
module tb_regfile_wport_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        sel;
    logic [7:0]  coll_cnt;

    int checks = 0;
    int errors = 0;

    // reference model: who has priority next under contention, and the expected write port
    int          next_pri;
    logic        exp_wr_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_sel;
    int          exp_cnt;
    logic [1:0]  last_g;

    regfile_wport_arbiter dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sel(sel), .coll_cnt(coll_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] mgnt();
        if (hold || !rst_n) return 2'b00;
        if (a_valid && b_valid) return next_pri == 0 ? 2'b01 : 2'b10;
        return {b_valid, a_valid};
    endfunction

    task automatic model_reset();
        next_pri = 0;
        exp_wr_en = 0;
        exp_addr = '0;
        exp_data = '0;
        exp_sel = 0;
        exp_cnt = 0;
    endtask

    // advance one clock with current inputs, updating the model at the edge; returns at the next negedge
    task automatic tick();
        logic [1:0] g;
        logic c;
        g = mgnt();
        c = a_valid & b_valid & ~hold & rst_n;
        last_g = g;
        @(posedge clk);
        if (g != 2'b00) begin
            exp_sel  = g[1];
            exp_addr = g[1] ? b_addr : a_addr;
            exp_data = g[1] ? b_data : a_data;
            exp_wr_en = exp_addr != 0;
            next_pri = g[1] ? 0 : 1;
        end else begin
            exp_wr_en = 0;
        end
        if (c && exp_cnt < 255) exp_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        a_valid = 1; a_addr = 5'd1; a_data = 32'hA1;
        b_valid = 1; b_addr = 5'd2; b_data = 32'hB2;
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got a=%b b=%b want 0 0", a_ready, b_ready);
        end
        tick();
        tick();
        checks++;
        if (wr_en !== 1'b0 || coll_cnt !== 8'd0 || sel !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: got en=%b cnt=%0d sel=%b addr=%0d data=%h want all zero", wr_en, coll_cnt, sel, wr_addr, wr_data);
        end
        rst_n = 1;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: got a=%b b=%b want 1 0", a_ready, b_ready);
        end
        tick();
        a_valid = 0; b_valid = 0;
        checks++;
        if (wr_en !== exp_wr_en || wr_addr !== exp_addr || sel !== 1'b0 || coll_cnt !== 8'd1) begin
            errors++;
            $display("FAIL reset_first_write: got en=%b addr=%0d sel=%b cnt=%0d want %b %0d 0 1", wr_en, wr_addr, sel, coll_cnt, exp_wr_en, exp_addr);
        end
    endtask

    task automatic test_single();
        a_valid = 1; a_addr = 5'd8; a_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got a=%b b=%b want 1 0", a_ready, b_ready);
        end
        tick();
        a_valid = 0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd8 || wr_data !== 32'hDEADBEEF || sel !== 1'b0) begin
            errors++;
            $display("FAIL single_write: got en=%b addr=%0d data=%h sel=%b want 1 8 deadbeef 0", wr_en, wr_addr, wr_data, sel);
        end
        tick();
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd8 || wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_one_shot: got en=%b addr=%0d data=%h want 0 8 deadbeef", wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_round_robin();
        int cnt0;
        b_valid = 1; b_addr = 5'd4; b_data = 32'h22;
        tick();
        cnt0 = exp_cnt;
        a_valid = 1; a_addr = 5'd3; a_data = 32'h11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got a=%b b=%b want %b %b", i, a_ready, b_ready, i % 2 == 0, i % 2 == 1);
            end
            tick();
            checks++;
            if (wr_en !== 1'b1 || sel !== logic'(i % 2) || wr_addr !== (i % 2 ? 5'd4 : 5'd3) || wr_data !== (i % 2 ? 32'h22 : 32'h11)) begin
                errors++;
                $display("FAIL rr_write[%0d]: got en=%b sel=%b addr=%0d data=%h", i, wr_en, sel, wr_addr, wr_data);
            end
        end
        checks++;
        if (coll_cnt !== 8'(cnt0 + 4)) begin
            errors++;
            $display("FAIL rr_coll_cnt: got %0d want %0d", coll_cnt, cnt0 + 4);
        end
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_zero_drop();
        b_valid = 1; b_addr = 5'd0; b_data = 32'h55;
        #1;
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: got b=%b want 1", b_ready);
        end
        tick();
        b_valid = 0;
        checks++;
        if (wr_en !== 1'b0 || sel !== 1'b1 || wr_addr !== 5'd0 || wr_data !== 32'h55) begin
            errors++;
            $display("FAIL zero_drop: got en=%b sel=%b addr=%0d data=%h want 0 1 0 55", wr_en, sel, wr_addr, wr_data);
        end
    endtask

    task automatic test_stall();
        int cnt0;
        logic [1:0] want;
        a_valid = 1; a_addr = 5'd9; a_data = 32'h99;
        b_valid = 1; b_addr = 5'd10; b_data = 32'hAA;
        tick();
        want = next_pri == 0 ? 2'b01 : 2'b10;
        cnt0 = exp_cnt;
        if (last_g[0]) begin a_addr = 5'd11; a_data = 32'hBB; end
        if (last_g[1]) begin b_addr = 5'd12; b_data = 32'hCC; end
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got a=%b b=%b want 0 0", i, a_ready, b_ready);
            end
            tick();
            checks++;
            if (wr_en !== 1'b0 || coll_cnt !== 8'(cnt0)) begin
                errors++;
                $display("FAIL stall_regs[%0d]: got en=%b cnt=%0d want 0 %0d", i, wr_en, coll_cnt, cnt0);
            end
        end
        hold = 0;
        #1;
        checks++;
        if ({b_ready, a_ready} !== want) begin
            errors++;
            $display("FAIL stall_resume: got %b want %b", {b_ready, a_ready}, want);
        end
        tick();
        a_valid = 0; b_valid = 0;
        checks++;
        if (wr_en !== exp_wr_en || sel !== want[1] || wr_addr !== exp_addr || wr_data !== exp_data) begin
            errors++;
            $display("FAIL stall_write: got en=%b sel=%b addr=%0d data=%h want %b %b %0d %h", wr_en, sel, wr_addr, wr_data, exp_wr_en, want[1], exp_addr, exp_data);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            hold = ($urandom % 4) == 0;
            #1;
            checks++;
            if ({b_ready, a_ready} !== mgnt()) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL rand_ready[%0d]: got %b want %b", i, {b_ready, a_ready}, mgnt());
            end
            tick();
            checks++;
            if (wr_en !== exp_wr_en || wr_addr !== exp_addr || wr_data !== exp_data || sel !== exp_sel || coll_cnt !== 8'(exp_cnt)) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL rand_out[%0d]: got en=%b addr=%0d data=%h sel=%b cnt=%0d want %b %0d %h %b %0d", i, wr_en, wr_addr, wr_data, sel, coll_cnt, exp_wr_en, exp_addr, exp_data, exp_sel, exp_cnt);
            end
            if (!a_valid || last_g[0]) begin
                a_valid = $urandom % 2; a_addr = 5'($urandom); a_data = $urandom;
            end
            if (!b_valid || last_g[1]) begin
                b_valid = $urandom % 2; b_addr = 5'($urandom); b_data = $urandom;
            end
        end
        hold = 0; a_valid = 0; b_valid = 0;
        tick();
    endtask

    task automatic test_saturation_reset();
        a_valid = 1; a_addr = 5'd3; a_data = 32'h11;
        b_valid = 1; b_addr = 5'd4; b_data = 32'h22;
        for (int i = 0; i < 300; i++) tick();
        checks++;
        if (coll_cnt !== 8'd255 || exp_cnt != 255) begin
            errors++;
            $display("FAIL sat_cnt: got %0d want 255", coll_cnt);
        end
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL sat_pre_reset_en: got %b want 1", wr_en);
        end
        #2;
        rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (wr_en !== 1'b0 || coll_cnt !== 8'd0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got en=%b cnt=%0d a=%b b=%b want 0 0 0 0", wr_en, coll_cnt, a_ready, b_ready);
        end
        @(negedge clk);
        a_valid = 0; b_valid = 0;
        rst_n = 1;
        tick();
        checks++;
        if (wr_en !== 1'b0 || coll_cnt !== 8'd0 || wr_addr !== 5'd0) begin
            errors++;
            $display("FAIL post_reset: got en=%b cnt=%0d addr=%0d want 0 0 0", wr_en, coll_cnt, wr_addr);
        end
    endtask

    initial begin
        last_g = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_drop();
        test_stall();
        test_random();
        test_saturation_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters:
  - A: ALU result, destination rd.
  - B: load data, destination rt.
- Arbitrates each cycle and registers the winning address and data.
- Drives the write-destination select (sel=0 picks A, 1 picks B) and the write enable into the register file.
- Writes to $zero are discarded; a saturating collision counter records cycles where both requesters compete.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- CNT_W, 8, collision counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hold  input  1  pipeline stall; no grants while high.
- a_valid  input  1  requester A has a write pending.
- a_addr  input  ADDR_W  A destination register.
- a_data  input  DATA_W  A write data.
- a_ready  output  1  A accepted this cycle (combinational).
- b_valid  input  1  requester B has a write pending.
- b_addr  input  ADDR_W  B destination register.
- b_data  input  DATA_W  B write data.
- b_ready  output  1  B accepted this cycle (combinational).
- wr_en  output  1  register-file write enable (registered).
- wr_addr  output  ADDR_W  register-file write address (registered).
- wr_data  output  DATA_W  register-file write data (registered).
- sel  output  1  source of current write: 0=A, 1=B (registered).
- coll_cnt  output  CNT_W  saturating count of collision cycles.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. All state clears immediately on rst_n low.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, sel=0, coll_cnt=0.
  - last_grant=B, so A has first priority after reset.
  - a_ready=b_ready=0 while rst_n low.
- Handshake:
  - A transfer occurs on a cycle where x_valid and x_ready are both high.
  - Once valid is asserted, the requester holds valid, addr and data stable until ready.
  - Ready never depends on a requester's own ready.
- Grant rules, combinational, evaluated each cycle:
  - hold=1: no grant; both readys 0.
  - Only one valid: grant it.
  - Both valid: grant the requester not in last_grant (round robin).
  - last_grant updates only on a grant.
- Fairness: a continuously valid requester is granted within 2 unheld cycles.
- Same-address conflicts get no special case; ordering follows grant order.
- Latency: grant in cycle N gives wr_en/wr_addr/wr_data/sel in cycle N+1, for exactly one cycle.
  - Granted address 0: request is consumed (ready=1) but wr_en=0 next cycle. wr_addr, wr_data and sel still update.
- No-grant cycle: wr_en=0 next cycle; wr_addr, wr_data and sel hold their previous values.
- Collision counter: coll_cnt increments in any cycle with a_valid & b_valid & ~hold, and saturates at all-ones.
- hold rising mid-contention: no grant and last_grant unchanged; arbitration resumes identically when hold falls.
- Reset asserted mid-operation: any in-flight registered write is dropped (wr_en forced 0); pending requests are not acknowledged.

Decomposition:
- Shared package regfile_arb_pkg holds:
  - constants REQ_A=0, REQ_B=1;
  - default widths DATA_W=32, ADDR_W=5;
  - ZERO_REG=5'd0.
- One sub-module: rr_arbiter2.
  - Two-input round-robin arbiter with a last_grant flop.
  - Inputs: req[1:0], en (driven by ~hold).
  - Output: one-hot gnt[1:0].
- The top level instantiates rr_arbiter2 plus the output register stage and the counter.

Test Plan:
- Reset: hold rst_n=0 with a_valid=b_valid=1 → a_ready=b_ready=0, wr_en=0, coll_cnt=0. Release rst_n, both valid → A granted first cycle.
- Single requester:
  - Stimulus: a_valid=1, a_addr=5'd8, a_data=32'hDEADBEEF.
  - Response: a_ready=1 the same cycle; next cycle wr_en=1, wr_addr=8, wr_data=DEADBEEF, sel=0.
- Round robin:
  - Stimulus: both valid for 4 cycles, with A=(3,32'h11) and B=(4,32'h22) re-presented after each grant.
  - Response: grants A,B,A,B; sel sequence 0,1,0,1; coll_cnt=4.
- $zero drop: b_valid=1, b_addr=0, b_data=32'h55 → b_ready=1; next cycle wr_en=0, sel=1.
- Stall: both valid with hold=1 for 3 cycles → no readys, wr_en=0, coll_cnt unchanged. Release hold → grant goes to the requester that was next before the stall.
- Saturation and async reset:
  - Drive 300 collision cycles with CNT_W=8 → coll_cnt=255.
  - Drop rst_n mid-cycle between clock edges → wr_en=0 and coll_cnt=0 immediately.
